ascon_perm_engine: RTL

Iterative Ascon permutation engine that applies p^a / p^b (1–12 rounds) to a 320-bit state.
- Each round is constant addition, 5-bit S-box layer, then per-word linear diffusion.
- Sits between the mode controllers (AEAD/hash sequencing) and the state register file, replacing standalone combinational round logic.
- UNROLL rounds are evaluated per clock, trading area against latency; a valid/ready handshake runs on both sides.

---
 rtl/ascon_pkg.sv | 45 ++++
 rtl/ascon_round.sv | 53 +++++
 rtl/ascon_perm_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation engine.
// The state packs x0 in the top word down to x4 in the bottom word.
package ascon_pkg;

    localparam int unsigned ROUNDS_MAX = 12;

    typedef logic [63:0]  word_t;
    typedef logic [319:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_e;

    // Rotation pairs of the linear diffusion layer, one pair per word.
    localparam int unsigned ROT_X0_A = 19;
    localparam int unsigned ROT_X0_B = 28;
    localparam int unsigned ROT_X1_A = 61;
    localparam int unsigned ROT_X1_B = 39;
    localparam int unsigned ROT_X2_A = 1;
    localparam int unsigned ROT_X2_B = 6;
    localparam int unsigned ROT_X3_A = 10;
    localparam int unsigned ROT_X3_B = 17;
    localparam int unsigned ROT_X4_A = 7;
    localparam int unsigned ROT_X4_B = 41;

    function automatic word_t xw(state_t s, int unsigned k);
        return s[319 - 64 * k -: 64];
    endfunction

    function automatic state_t pack_state(word_t x0, word_t x1, word_t x2,
                                          word_t x3, word_t x4);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [7:0] rc(logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic word_t ror(word_t x, int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
// With en low the stage passes its input straight through.
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     state_in,
    input  logic [3:0] rnd,
    input  logic       en,
    output state_t     state_out
);

    word_t x0, x1, x2, x3, x4;
    word_t t0, t1, t2, t3, t4;
    word_t y0, y1, y2, y3, y4;

    always_comb begin
        x0 = xw(state_in, 0);
        x1 = xw(state_in, 1);
        x2 = xw(state_in, 2);
        x3 = xw(state_in, 3);
        x4 = xw(state_in, 4);

        x2 = x2 ^ {56'h0, rc(rnd)};

        // Bitsliced S-box across all 64 columns.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        y0 = x0 ^ ror(x0, ROT_X0_A) ^ ror(x0, ROT_X0_B);
        y1 = x1 ^ ror(x1, ROT_X1_A) ^ ror(x1, ROT_X1_B);
        y2 = x2 ^ ror(x2, ROT_X2_A) ^ ror(x2, ROT_X2_B);
        y3 = x3 ^ ror(x3, ROT_X3_A) ^ ror(x3, ROT_X3_B);
        y4 = x4 ^ ror(x4, ROT_X4_A) ^ ror(x4, ROT_X4_B);

        state_out = en ? pack_state(y0, y1, y2, y3, y4) : state_in;
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon p^a / p^b engine: UNROLL chained rounds per clock,
// valid/ready handshake on request and result sides.
module ascon_perm_engine
    import ascon_pkg::*;
#(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned NR_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NR_W-1:0] nr,
    input  logic [319:0]    state_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [319:0]    state_out
);

    fsm_e                  fsm_q;
    state_t                st_q;
    logic [3:0]            rnd_q;
    logic [3:0]            nr_clamp;
    logic [4:0]            rnd_sum;
    logic [3:0]            rnd_next;
    logic [UNROLL:0][319:0] chain;

    always_comb begin
        nr_clamp = (nr > NR_W'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : 4'(nr);
        rnd_sum  = 5'(rnd_q) + 5'(UNROLL);
        rnd_next = (rnd_sum >= 5'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rnd_sum[3:0];
    end

    assign chain[0] = st_q;

    // Stage s runs round rnd_q+s; stages past the last round are bypassed.
    for (genvar s = 0; s < UNROLL; s++) begin : g_rnd
        logic [4:0] idx;
        assign idx = 5'(rnd_q) + 5'(s);
        ascon_round u_round (
            .state_in  (chain[s]),
            .rnd       (idx[3:0]),
            .en        (idx < 5'(ROUNDS_MAX)),
            .state_out (chain[s+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            st_q      <= '0;
            rnd_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        st_q     <= state_in;
                        rnd_q    <= 4'(ROUNDS_MAX) - nr_clamp;
                        in_ready <= 1'b0;
                        if (nr_clamp == 4'd0) begin
                            fsm_q     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            fsm_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    st_q  <= chain[UNROLL];
                    rnd_q <= rnd_next;
                    if (rnd_next == 4'(ROUNDS_MAX)) begin
                        fsm_q     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = st_q;

endmodule
